// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the branch-resolution slice.
//  - Opcode constants for the control-transfer instructions handled here.
//  - Bit positions of N, Z and P within the condition-code register.
//  - Resolver state encoding.
//  - br_cond(): BR condition test (instruction mask against current NZP).
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;  // JSR when IR[11]=1, JSRR otherwise
  localparam logic [3:0] OP_JMP = 4'b1100;  // JMP, and RET as JMP R7

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_TARGET,
    S_LINK,
    S_FIN
  } br_state_t;

  // A branch is taken when any flag selected by the instruction is set.
  function automatic logic br_cond(input logic [2:0] mask, input logic [2:0] nzp);
    return (mask[NZP_N] & nzp[NZP_N]) |
           (mask[NZP_Z] & nzp[NZP_Z]) |
           (mask[NZP_P] & nzp[NZP_P]);
  endfunction

endpackage

// File: rtl/lc3_sext.sv
// Parameterised sign extender: replicates the MSB of an IN_W-bit field up to
// OUT_W bits. Used for the PC-relative offsets of BR (9 bits) and JSR (11 bits).
// Ports:
//  in_val   in   IN_W   field to extend
//  out_val  out  OUT_W  sign-extended result
module lc3_sext #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val
);

  assign out_val = {{(OUT_W-IN_W){in_val[IN_W-1]}}, in_val};

endmodule

// File: rtl/lc3_branch_resolve.sv
// LC-3 control-transfer resolver. Takes the NZP/BEN registers and resolves
// BR, JMP/RET and JSR/JSRR into a PC load and, for subroutine calls, a link
// write of the pre-jump PC into R7.
//
// Sequence: IDLE -> EVAL -> TARGET -> [LINK] -> FIN -> IDLE.
// Start-to-Done latency is 3 cycles (BR/JMP/illegal) or 4 cycles (JSR/JSRR).
// Start is only honoured in IDLE; requests while Busy are dropped.
//
// Optional feature macro: LC3_BRANCH_STATS_EN adds the saturating BR counters
// Br_Taken_Cnt / Br_Total_Cnt (updated in FIN for BR only).
//
// Ports:
//  Clk, Reset_n    clock, asynchronous active-low reset
//  Start           request from the control FSM
//  IR, PC          instruction and incremented PC, latched on accept
//  NZP_Val,BEN_Val condition codes and branch-enable register
//  SR1_Out/SR1     register-file read port for BaseR (SR1 = latched IR[8:6])
//  PC_Next/LD_PC   resolved target and one-cycle PC load strobe
//  REG_Data/DR/LD_REG  link value, destination and one-cycle write strobe
//  Busy/Done       in-flight flag and one-cycle completion pulse
//  Taken/Illegal   status qualified by Done
//  BEN_Err         sticky: BEN_Val disagreed with the recomputed BR condition
module lc3_branch_resolve
  import lc3_pkg::*;
#(
  parameter int W        = 16,
  parameter int LINK_REG = 7
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [15:0]  IR,
  input  logic [W-1:0] PC,
  input  logic [2:0]   NZP_Val,
  input  logic         BEN_Val,
  input  logic [W-1:0] SR1_Out,
  output logic [2:0]   SR1,
  output logic [W-1:0] PC_Next,
  output logic         LD_PC,
  output logic [W-1:0] REG_Data,
  output logic [2:0]   DR,
  output logic         LD_REG,
  output logic         Busy,
  output logic         Done,
  output logic         Taken,
  output logic         Illegal,
  output logic         BEN_Err
`ifdef LC3_BRANCH_STATS_EN
  ,
  output logic [15:0]  Br_Taken_Cnt,
  output logic [15:0]  Br_Total_Cnt
`endif
);

  br_state_t    state;
  logic [15:0]  ir_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] target_q;
  logic         taken_q;

  logic [3:0]   op;
  logic         is_br, is_jsr, is_jmp, cond;
  logic [W-1:0] off9_ext, off11_ext;

  assign op     = ir_q[15:12];
  assign is_br  = (op == OP_BR);
  assign is_jsr = (op == OP_JSR);
  assign is_jmp = (op == OP_JMP);
  assign cond   = br_cond(ir_q[11:9], NZP_Val);
  assign SR1    = ir_q[8:6];

  lc3_sext #(.IN_W(9), .OUT_W(W)) u_sext9 (
    .in_val  (ir_q[8:0]),
    .out_val (off9_ext)
  );

  lc3_sext #(.IN_W(11), .OUT_W(W)) u_sext11 (
    .in_val  (ir_q[10:0]),
    .out_val (off11_ext)
  );

  // NOTE: all state below is updated with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      ir_q     <= '0;
      pc_q     <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      PC_Next  <= '0;
      LD_PC    <= 1'b0;
      REG_Data <= '0;
      DR       <= '0;
      LD_REG   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Taken    <= 1'b0;
      Illegal  <= 1'b0;
      BEN_Err  <= 1'b0;
`ifdef LC3_BRANCH_STATS_EN
      Br_Taken_Cnt <= '0;
      Br_Total_Cnt <= '0;
`endif
    end else begin
      // NOTE: strobes default low every cycle, so a strobe set in one state
      // can never stretch beyond a single clock.
      LD_PC   <= 1'b0;
      LD_REG  <= 1'b0;
      Done    <= 1'b0;
      Taken   <= 1'b0;
      Illegal <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Start) begin
            ir_q  <= IR;
            pc_q  <= PC;
            Busy  <= 1'b1;
            state <= S_EVAL;
          end
        end

        S_EVAL: begin
          taken_q <= is_br ? cond : (is_jmp | is_jsr);
          if (is_br && (BEN_Val != cond)) BEN_Err <= 1'b1;
          state <= S_TARGET;
        end

        S_TARGET: begin
          if (is_br)
            target_q <= pc_q + off9_ext;
          else if (is_jsr && ir_q[11])
            target_q <= pc_q + off11_ext;
          else
            target_q <= SR1_Out;  // JMP/RET/JSRR base register
          state <= is_jsr ? S_LINK : S_FIN;
        end

        // The link value is the latched PC: BaseR was already sampled in
        // TARGET, so JSRR R7 jumps through the old R7.
        S_LINK: begin
          LD_REG   <= 1'b1;
          DR       <= 3'(LINK_REG);
          REG_Data <= pc_q;
          state    <= S_FIN;
        end

        S_FIN: begin
          Done    <= 1'b1;
          Busy    <= 1'b0;
          Taken   <= taken_q;
          Illegal <= ~(is_br | is_jsr | is_jmp);
          if (taken_q) begin
            LD_PC   <= 1'b1;
            PC_Next <= target_q;
          end
`ifdef LC3_BRANCH_STATS_EN
          if (is_br) begin
            if (Br_Total_Cnt != 16'hFFFF) Br_Total_Cnt <= Br_Total_Cnt + 16'd1;
            if (taken_q && (Br_Taken_Cnt != 16'hFFFF))
              Br_Taken_Cnt <= Br_Taken_Cnt + 16'd1;
          end
`endif
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_branch_resolve.sv
// Self-checking bench for lc3_branch_resolve: a table of directed vectors,
// hand-written sequences for Start-while-Busy and reset mid-operation, and
// randomised instructions checked against an arithmetic reference model.
module tb_lc3_branch_resolve;

  logic        Clk, Reset_n, Start;
  logic [15:0] IR, PC, SR1_Out;
  logic [2:0]  NZP_Val;
  logic        BEN_Val;
  logic [2:0]  SR1, DR;
  logic [15:0] PC_Next, REG_Data;
  logic        LD_PC, LD_REG, Busy, Done, Taken, Illegal, BEN_Err;
`ifdef LC3_BRANCH_STATS_EN
  logic [15:0] Br_Taken_Cnt, Br_Total_Cnt;
`endif

  lc3_branch_resolve dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .IR       (IR),
    .PC       (PC),
    .NZP_Val  (NZP_Val),
    .BEN_Val  (BEN_Val),
    .SR1_Out  (SR1_Out),
    .SR1      (SR1),
    .PC_Next  (PC_Next),
    .LD_PC    (LD_PC),
    .REG_Data (REG_Data),
    .DR       (DR),
    .LD_REG   (LD_REG),
    .Busy     (Busy),
    .Done     (Done),
    .Taken    (Taken),
    .Illegal  (Illegal),
    .BEN_Err  (BEN_Err)
`ifdef LC3_BRANCH_STATS_EN
    ,
    .Br_Taken_Cnt (Br_Taken_Cnt),
    .Br_Total_Cnt (Br_Total_Cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [2:0]  nzp;
    logic        ben;
    logic [15:0] sr1;
  } in_t;

  typedef struct {
    int          lat;
    logic        taken;
    logic        illegal;
    logic        ld_pc;
    logic [15:0] pc_next;
    logic        ld_reg;
    logic [15:0] link;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t exp;
  } vec_t;

  typedef struct {
    int          done_cyc, n_done, n_ld_pc, ld_pc_cyc, n_ld_reg, ld_reg_cyc;
    logic [15:0] pc_next, reg_data;
    logic [2:0]  dr, sr1;
    logic        taken, illegal, busy0, busy_at_done;
  } obs_t;

  int checks = 0;
  int errors = 0;
  logic exp_ben_err = 1'b0;
  int exp_br_total = 0;
  int exp_br_taken = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics, using plain integer math.
  function automatic exp_t ref_model(input in_t v);
    exp_t e;
    int   off;
    e = '{lat: 3, taken: 1'b0, illegal: 1'b0, ld_pc: 1'b0, pc_next: 16'h0,
          ld_reg: 1'b0, link: 16'h0};
    case (v.ir[15:12])
      4'h0: begin
        off = int'(v.ir[8:0]);
        if (off >= 256) off -= 512;
        e.taken   = ((v.ir[11:9] & v.nzp) != 3'b000);
        e.pc_next = 16'(int'(v.pc) + off);
      end
      4'h4: begin
        e.lat    = 4;
        e.taken  = 1'b1;
        e.ld_reg = 1'b1;
        e.link   = v.pc;
        if (v.ir[11]) begin
          off = int'(v.ir[10:0]);
          if (off >= 1024) off -= 2048;
          e.pc_next = 16'(int'(v.pc) + off);
        end else begin
          e.pc_next = v.sr1;
        end
      end
      4'hC: begin
        e.taken   = 1'b1;
        e.pc_next = v.sr1;
      end
      default: e.illegal = 1'b1;
    endcase
    e.ld_pc = e.taken;
    return e;
  endfunction

  // Issue one instruction and observe 8 cycles after acceptance.
  // Cycle k is sampled on the falling edge following the k-th rising edge
  // after the accepting edge.
  task automatic run_op(input in_t v, output obs_t o);
    o = '{default: 0};
    @(negedge Clk);
    IR = v.ir; PC = v.pc; NZP_Val = v.nzp; BEN_Val = v.ben; SR1_Out = v.sr1;
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start   = 1'b0;
    o.busy0 = Busy;
    o.sr1   = SR1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (LD_PC === 1'b1) begin
        o.n_ld_pc++; o.ld_pc_cyc = k; o.pc_next = PC_Next;
      end
      if (LD_REG === 1'b1) begin
        o.n_ld_reg++; o.ld_reg_cyc = k; o.dr = DR; o.reg_data = REG_Data;
      end
      if (Done === 1'b1) begin
        o.n_done++;
        if (o.done_cyc == 0) begin
          o.done_cyc = k; o.taken = Taken; o.illegal = Illegal; o.busy_at_done = Busy;
        end
      end
    end
  endtask

  task automatic do_vec(input string tag, input in_t v, input exp_t e);
    obs_t o;
    logic cond;
    run_op(v, o);
    cond = ((v.ir[11:9] & v.nzp) != 3'b000);
    if (v.ir[15:12] == 4'h0) begin
      if (v.ben != cond) exp_ben_err = 1'b1;
      if (exp_br_total < 65535) exp_br_total++;
      if (e.taken && exp_br_taken < 65535) exp_br_taken++;
    end
    check({tag, " latency"}, 32'(o.done_cyc), 32'(e.lat));
    check({tag, " done_count"}, 32'(o.n_done), 32'd1);
    check({tag, " ld_pc_count"}, 32'(o.n_ld_pc), 32'(e.ld_pc));
    if (e.ld_pc) begin
      check({tag, " ld_pc_cycle"}, 32'(o.ld_pc_cyc), 32'(e.lat));
      check({tag, " pc_next"}, 32'(o.pc_next), 32'(e.pc_next));
    end
    check({tag, " ld_reg_count"}, 32'(o.n_ld_reg), 32'(e.ld_reg));
    if (e.ld_reg) begin
      check({tag, " ld_reg_cycle"}, 32'(o.ld_reg_cyc), 32'd3);
      check({tag, " dr"}, 32'(o.dr), 32'd7);
      check({tag, " reg_data"}, 32'(o.reg_data), 32'(e.link));
    end
    check({tag, " taken"}, 32'(o.taken), 32'(e.taken));
    check({tag, " illegal"}, 32'(o.illegal), 32'(e.illegal));
    check({tag, " busy_after_accept"}, 32'(o.busy0), 32'd1);
    check({tag, " busy_at_done"}, 32'(o.busy_at_done), 32'd0);
    check({tag, " sr1"}, 32'(o.sr1), 32'(v.ir[8:6]));
    check({tag, " ben_err"}, 32'(BEN_Err), 32'(exp_ben_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},     32'(Busy),     32'd0);
    check({tag, " done"},     32'(Done),     32'd0);
    check({tag, " ld_pc"},    32'(LD_PC),    32'd0);
    check({tag, " ld_reg"},   32'(LD_REG),   32'd0);
    check({tag, " pc_next"},  32'(PC_Next),  32'd0);
    check({tag, " reg_data"}, 32'(REG_Data), 32'd0);
    check({tag, " dr"},       32'(DR),       32'd0);
    check({tag, " sr1"},      32'(SR1),      32'd0);
    check({tag, " taken"},    32'(Taken),    32'd0);
    check({tag, " illegal"},  32'(Illegal),  32'd0);
    check({tag, " ben_err"},  32'(BEN_Err),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    obs_t o;
    in_t  v;
    int   n_done, n_busy;

    tbl[0] = '{'{16'h0405, 16'h3001, 3'b010, 1'b1, 16'h0000},
               '{3, 1'b1, 1'b0, 1'b1, 16'h3006, 1'b0, 16'h0000}};  // BRz taken
    tbl[1] = '{'{16'h0805, 16'h3001, 3'b001, 1'b0, 16'h0000},
               '{3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000}};  // BRn not taken
    tbl[2] = '{'{16'h4FFF, 16'h0000, 3'b010, 1'b0, 16'h1234},
               '{4, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0000}};  // JSR wrap
    tbl[3] = '{'{16'hC0C0, 16'h3001, 3'b000, 1'b0, 16'h4000},
               '{3, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h0000}};  // JMP R3
    tbl[4] = '{'{16'hF000, 16'h1234, 3'b111, 1'b0, 16'h5678},
               '{3, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000}};  // illegal
    tbl[5] = '{'{16'h0010, 16'h2000, 3'b111, 1'b0, 16'h0000},
               '{3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000}};  // BR nzp=000
    tbl[6] = '{'{16'h0FFF, 16'h0000, 3'b100, 1'b1, 16'h0000},
               '{3, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000}};  // BR nzp=111
    tbl[7] = '{'{16'h41C0, 16'h2222, 3'b000, 1'b0, 16'h5555},
               '{4, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b1, 16'h2222}};  // JSRR R7
    tbl[8] = '{'{16'h03F0, 16'h3010, 3'b001, 1'b1, 16'h0000},
               '{3, 1'b1, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000}};  // BRp, -16
    tbl[9] = '{'{16'hC1C0, 16'h3001, 3'b010, 1'b0, 16'hABCD},
               '{3, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000}};  // RET

    Reset_n = 1'b0; Start = 1'b0;
    IR = '0; PC = '0; NZP_Val = '0; BEN_Val = 1'b0; SR1_Out = '0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++)
      do_vec($sformatf("tbl%0d", i), tbl[i].in, tbl[i].exp);
    check("tbl ben_err_clear", 32'(BEN_Err), 32'd0);

    // BRp with P set but BEN=0: BEN_Err sets and stays set.
    v = '{16'h0205, 16'h3001, 3'b001, 1'b0, 16'h0000};
    do_vec("ben_mismatch", v, '{3, 1'b1, 1'b0, 1'b1, 16'h3006, 1'b0, 16'h0000});
    check("ben_err_set", 32'(BEN_Err), 32'd1);
    v = '{16'hC0C0, 16'h3001, 3'b010, 1'b1, 16'h1111};
    do_vec("ben_sticky", v, '{3, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000});
    check("ben_err_sticky", 32'(BEN_Err), 32'd1);

    // Start while Busy: second request (illegal opcode) must be dropped.
    @(negedge Clk);
    IR = 16'h0405; PC = 16'h3001; NZP_Val = 3'b010; BEN_Val = 1'b1; SR1_Out = 16'h0;
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    IR = 16'hF000; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("busy_start done", 32'(Done), 32'd1);
    check("busy_start ld_pc", 32'(LD_PC), 32'd1);
    check("busy_start pc_next", 32'(PC_Next), 32'h3006);
    check("busy_start illegal", 32'(Illegal), 32'd0);
    exp_br_total++; exp_br_taken++;
    n_done = 0; n_busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done === 1'b1) n_done++;
      if (Busy === 1'b1) n_busy++;
    end
    check("busy_start no_second_done", 32'(n_done), 32'd0);
    check("busy_start no_second_busy", 32'(n_busy), 32'd0);

    // Reset asserted during TARGET of a JSR: everything clears at once.
    @(negedge Clk);
    IR = 16'h4FFF; PC = 16'h0000; NZP_Val = 3'b000; BEN_Val = 1'b0;
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("mid_reset busy_before", 32'(Busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_ben_err = 1'b0; exp_br_total = 0; exp_br_taken = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (LD_PC === 1'b1 || LD_REG === 1'b1 || Done === 1'b1 || Busy === 1'b1) n_done++;
    end
    check("mid_reset no_strobes", 32'(n_done), 32'd0);

    // Randomised instructions against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic       cond;
      case ($urandom_range(0, 3))
        0: op = 4'h0;
        1: op = 4'h4;
        2: op = 4'hC;
        default: begin
          op = 4'($urandom_range(1, 15));
          if (op == 4'h4 || op == 4'hC) op = 4'hF;
        end
      endcase
      v.ir  = {op, 12'($urandom)};
      v.pc  = 16'($urandom);
      v.nzp = 3'($urandom);
      v.sr1 = 16'($urandom);
      cond  = ((v.ir[11:9] & v.nzp) != 3'b000);
      v.ben = ($urandom_range(0, 3) == 0) ? ~cond : cond;
      do_vec($sformatf("rnd%0d", i), v, ref_model(v));
    end

`ifdef LC3_BRANCH_STATS_EN
    check("stats br_total", 32'(Br_Total_Cnt), 32'(exp_br_total));
    check("stats br_taken", 32'(Br_Taken_Cnt), 32'(exp_br_taken));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
